// File: rtl/lcd_line_writer.sv
// HD44780 single-line writer: power-on wait, 8-bit init, then one 20-character frame per refresh.
// Optional macro LCD_ASCII_CONV_EN maps snapshot bytes 0x00-0x09 to ASCII '0'-'9'.

module lcd_char_conv (
    input  logic [7:0] raw,
    output logic [7:0] txt
);
`ifdef LCD_ASCII_CONV_EN
    assign txt = (raw <= 8'h09) ? (raw + 8'h30) : raw;
`else
    assign txt = raw;
`endif
endmodule

module lcd_line_writer #(
    parameter int E_PULSE_CYC      = 25,
    parameter int CMD_WAIT_CYC     = 2500,
    parameter int CLR_WAIT_CYC     = 100000,
    parameter int POWERON_WAIT_CYC = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [159:0] lcd_data,
    input  logic         refresh,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_db,
    output logic         init_done,
    output logic         busy,
    output logic         frame_done
);
    localparam int          NUM_COLS = 20;
    localparam logic [4:0]  LAST_COL = 5'(NUM_COLS - 1);
    localparam logic [31:0] PWR_LAST = 32'(POWERON_WAIT_CYC - 1);
    localparam logic [31:0] E_LAST   = 32'(E_PULSE_CYC - 1);
    localparam logic [31:0] CMD_LAST = 32'(CMD_WAIT_CYC - 1);
    localparam logic [31:0] CLR_LAST = 32'(CLR_WAIT_CYC - 1);

    typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, FRAME} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

    state_t                     state;
    phase_t                     phase;
    logic [31:0]                cnt;
    logic [1:0]                 init_idx;
    logic [4:0]                 col;
    logic                       data_phase;
    logic [NUM_COLS-1:0][7:0]   snap;
    logic [NUM_COLS-1:0][7:0]   chars;
    logic [31:0]                wait_last;

    // snap[19] holds column 0 (lcd_data[159:152])
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_conv
        lcd_char_conv u_conv (.raw(snap[c]), .txt(chars[c]));
    end

    assign lcd_rw    = 1'b0;
    assign wait_last = (!lcd_rs && lcd_db == 8'h01) ? CLR_LAST : CMD_LAST;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        frame_done <= 1'b0;
        if (rst) begin
            state      <= PWR_WAIT;
            phase      <= PH_SETUP;
            cnt        <= '0;
            init_idx   <= '0;
            col        <= '0;
            data_phase <= 1'b0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_db     <= 8'h00;
            init_done  <= 1'b0;
            busy       <= 1'b1;
            snap       <= '0;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        cnt      <= '0;
                        state    <= INIT;
                        phase    <= PH_SETUP;
                        init_idx <= '0;
                        lcd_rs   <= 1'b0;
                        lcd_db   <= init_cmd(2'd0);
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                INIT, FRAME: begin
                    case (phase)
                        PH_SETUP: begin
                            lcd_e <= 1'b1;
                            cnt   <= '0;
                            phase <= PH_PULSE;
                        end
                        PH_PULSE: begin
                            if (cnt == E_LAST) begin
                                lcd_e <= 1'b0;
                                cnt   <= '0;
                                phase <= PH_WAIT;
                            end else begin
                                cnt <= cnt + 32'd1;
                            end
                        end
                        PH_WAIT: begin
                            if (cnt != wait_last) begin
                                cnt <= cnt + 32'd1;
                            end else begin
                                // byte finished: load the next one (its setup cycle) or leave
                                cnt   <= '0;
                                phase <= PH_SETUP;
                                if (state == INIT) begin
                                    if (init_idx == 2'd3) begin
                                        init_done <= 1'b1;
                                        busy      <= 1'b0;
                                        state     <= IDLE;
                                    end else begin
                                        init_idx <= init_idx + 2'd1;
                                        lcd_db   <= init_cmd(init_idx + 2'd1);
                                    end
                                end else if (!data_phase) begin
                                    data_phase <= 1'b1;
                                    lcd_rs     <= 1'b1;
                                    lcd_db     <= chars[LAST_COL];
                                end else if (col == LAST_COL) begin
                                    frame_done <= 1'b1;
                                    busy       <= 1'b0;
                                    state      <= IDLE;
                                end else begin
                                    col    <= col + 5'd1;
                                    lcd_db <= chars[LAST_COL - col - 5'd1];
                                end
                            end
                        end
                        default: phase <= PH_SETUP;
                    endcase
                end
                IDLE: begin
                    if (refresh) begin
                        snap       <= lcd_data;
                        state      <= FRAME;
                        busy       <= 1'b1;
                        phase      <= PH_SETUP;
                        col        <= '0;
                        data_phase <= 1'b0;
                        lcd_rs     <= 1'b0;
                        lcd_db     <= 8'h80;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_line_writer.sv
// Directed bench for lcd_line_writer with short timing parameters; every cycle of each byte is checked.
module tb_lcd_line_writer;
    localparam int E  = 2;
    localparam int CW = 3;
    localparam int CL = 8;
    localparam int PW = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         refresh = 1'b0;
    logic [159:0] lcd_data = '0;
    logic         lcd_e, lcd_rs, lcd_rw, init_done, busy, frame_done;
    logic [7:0]   lcd_db;

    int checks = 0;
    int errors = 0;

    logic [7:0] pat  [20] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h05, 8'h09, 8'h20, 8'h03, 8'h01,
                              8'h48, 8'h49, 8'h2A, 8'h00, 8'h0A, 8'h7F, 8'hFF, 8'h30, 8'h39, 8'h41};
`ifdef LCD_ASCII_CONV_EN
    logic [7:0] sent [20] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h35, 8'h39, 8'h20, 8'h33, 8'h31,
                              8'h48, 8'h49, 8'h2A, 8'h30, 8'h0A, 8'h7F, 8'hFF, 8'h30, 8'h39, 8'h41};
`else
    logic [7:0] sent [20] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h05, 8'h09, 8'h20, 8'h03, 8'h01,
                              8'h48, 8'h49, 8'h2A, 8'h00, 8'h0A, 8'h7F, 8'hFF, 8'h30, 8'h39, 8'h41};
`endif
    logic [7:0] all41 [20];

    always #5 clk = ~clk;

    lcd_line_writer #(
        .E_PULSE_CYC(E), .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(CL), .POWERON_WAIT_CYC(PW)
    ) dut (
        .clk(clk), .rst(rst), .lcd_data(lcd_data), .refresh(refresh),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db),
        .init_done(init_done), .busy(busy), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {frame_done, busy, lcd_e, lcd_rs, lcd_db}
    function automatic logic [31:0] bus_vec();
        return 32'({frame_done, busy, lcd_e, lcd_rs, lcd_db});
    endfunction

    task automatic expect_byte(input string tag, input logic rs, input logic [7:0] db, input int wt);
        @(negedge clk);
        chk({tag, "_setup"}, bus_vec(), 32'({2'b01, 1'b0, rs, db}));
        for (int i = 0; i < E; i++) begin
            @(negedge clk);
            chk({tag, "_pulse"}, bus_vec(), 32'({2'b01, 1'b1, rs, db}));
        end
        for (int i = 0; i < wt; i++) begin
            @(negedge clk);
            chk({tag, "_wait"}, bus_vec(), 32'({2'b01, 1'b0, rs, db}));
        end
    endtask

    task automatic check_reset(input string tag);
        chk(tag, 32'({lcd_e, lcd_rs, lcd_rw, lcd_db, init_done, busy, frame_done}),
            32'({3'b000, 8'h00, 3'b010}));
    endtask

    // Entered at the negedge of the first power-on cycle, just after rst drops.
    task automatic power_on_and_init(input string tag);
        for (int i = 1; i < PW; i++) begin
            @(negedge clk);
            chk({tag, "_pwr"}, 32'({lcd_e, busy, init_done}), 32'(3'b010));
            if (i == 4) refresh = 1'b1;
            if (i == 5) refresh = 1'b0;
        end
        expect_byte({tag, "_38"}, 1'b0, 8'h38, CW);
        expect_byte({tag, "_0C"}, 1'b0, 8'h0C, CW);
        expect_byte({tag, "_06"}, 1'b0, 8'h06, CW);
        expect_byte({tag, "_01"}, 1'b0, 8'h01, CL);
        @(negedge clk);
        chk({tag, "_idle"}, 32'({init_done, busy, lcd_e, frame_done}), 32'(4'b1000));
        @(negedge clk);
        chk({tag, "_idle2"}, 32'({init_done, busy, lcd_e, frame_done}), 32'(4'b1000));
    endtask

    // Entered at a negedge in IDLE with refresh already high; leaves at the frame_done cycle.
    task automatic run_frame(input string tag, input logic [7:0] ex [20], input int change_col,
                             input bit drop_refresh);
        expect_byte({tag, "_80"}, 1'b0, 8'h80, CW);
        if (drop_refresh) refresh = 1'b0;
        for (int c = 0; c < 20; c++) begin
            expect_byte($sformatf("%s_col%0d", tag, c), 1'b1, ex[c], CW);
            if (c == change_col) lcd_data = {20{8'h41}};
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'({frame_done, busy, lcd_e}), 32'(3'b100));
    endtask

    initial begin
        foreach (all41[i]) all41[i] = 8'h41;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        power_on_and_init("init");

        for (int c = 0; c < 20; c++) lcd_data[159 - 8*c -: 8] = pat[c];
        refresh = 1'b1;
        run_frame("f1", sent, 3, 1'b1);
        @(negedge clk);
        chk("f1_after", 32'({frame_done, busy}), 32'(2'b00));

        refresh = 1'b1;
        run_frame("f2", all41, -1, 1'b0);
        run_frame("f3", all41, -1, 1'b1);
        @(negedge clk);
        chk("f3_after", 32'({frame_done, busy}), 32'(2'b00));

        refresh = 1'b1;
        expect_byte("f4_80", 1'b0, 8'h80, CW);
        refresh = 1'b0;
        for (int c = 0; c < 7; c++) expect_byte($sformatf("f4_col%0d", c), 1'b1, 8'h41, CW);
        @(negedge clk);
        chk("f4_col7_setup", bus_vec(), 32'({2'b01, 1'b0, 1'b1, 8'h41}));
        @(negedge clk);
        chk("f4_col7_pulse", bus_vec(), 32'({2'b01, 1'b1, 1'b1, 8'h41}));
        rst = 1'b1;
        @(negedge clk);
        check_reset("midbyte_reset");
        rst = 1'b0;
        power_on_and_init("reinit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
